// File: rtl/audio_level_meter.sv
// rtl/audio_level_meter.sv - windowed mean/peak audio level meter with decaying peak hold
//
// Purpose:
//   Accumulates the absolute deviation from midscale (128) of offset-binary
//   audio samples over windows of 2^WINDOW_LOG2 accepted samples. At each
//   window completion it publishes the mean deviation (level), the maximum
//   deviation (peak), a thermometer bar of level, a clip flag and a decaying
//   peak-hold value, and pulses level_valid for one cycle.
//
// Parameters:
//   WINDOW_LOG2  window length is 2^WINDOW_LOG2 samples (1..12)
//   DECAY_STEP   peak-hold decrement per completed window (1..128)
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   sample_valid single-cycle strobe qualifying sample
//   sample       8-bit unsigned offset-binary sample, midscale 128
//   level        mean absolute deviation of the last completed window
//   peak         maximum absolute deviation of the last completed window
//   peak_hold    decaying peak-hold value
//   bar          thermometer code: bar[i] = (level >= 16*(i+1))
//   clip         last completed window contained a 0 or 255 sample
//   level_valid  one-cycle pulse when the outputs above were updated

module audio_level_meter #(
  parameter int WINDOW_LOG2 = 8,
  parameter int DECAY_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic [7:0] level,
  output logic [7:0] peak,
  output logic [7:0] peak_hold,
  output logic [7:0] bar,
  output logic       clip,
  output logic       level_valid
);

  localparam int          ACC_W = 8 + WINDOW_LOG2;
  localparam logic [7:0]  DECAY = 8'(DECAY_STEP);

  logic [ACC_W-1:0]       r_acc;
  logic [WINDOW_LOG2-1:0] r_cnt;
  logic [7:0]             r_max;
  logic                   r_clip;

  logic [7:0]             w_mag;
  logic                   w_clip_cond;
  logic                   w_last;
  logic [ACC_W-1:0]       w_sum;
  logic [7:0]             w_level;
  logic [7:0]             w_peak;
  logic [7:0]             w_bar;
  logic [7:0]             w_decayed;
  logic [7:0]             w_hold_next;

  // Deviation from midscale; sample 0 yields 128, sample 255 yields 127.
  always_comb begin
    if (sample >= 8'd128) w_mag = sample - 8'd128;
    else                  w_mag = 8'd128 - sample;
  end

  assign w_clip_cond = (sample == 8'd0) || (sample == 8'd255);
  assign w_last      = (r_cnt == {WINDOW_LOG2{1'b1}});

  // Worst case the full window sums to 128 * 2^WINDOW_LOG2, which fits ACC_W
  // bits, so the mean after the shift never exceeds 128.
  assign w_sum   = r_acc + ACC_W'(w_mag);
  assign w_level = w_sum[WINDOW_LOG2 +: 8];
  assign w_peak  = (w_mag > r_max) ? w_mag : r_max;

  always_comb begin
    w_bar = 8'd0;
    for (int i = 0; i < 8; i++) begin
      w_bar[i] = (w_level >= 8'(16 * (i + 1)));
    end
  end

  // Peak hold follows any new peak at or above it; otherwise it decays by
  // DECAY without wrapping below zero and never drops under the new peak.
  assign w_decayed = (peak_hold > DECAY) ? (peak_hold - DECAY) : 8'd0;

  always_comb begin
    if (w_peak >= peak_hold)     w_hold_next = w_peak;
    else if (w_decayed > w_peak) w_hold_next = w_decayed;
    else                         w_hold_next = w_peak;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_max       <= 8'd0;
      r_clip      <= 1'b0;
      level       <= 8'd0;
      peak        <= 8'd0;
      peak_hold   <= 8'd0;
      bar         <= 8'd0;
      clip        <= 1'b0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (sample_valid) begin
        if (w_last) begin
          // Results include the closing sample; running state restarts so a
          // sample in the level_valid cycle opens the next window.
          level       <= w_level;
          peak        <= w_peak;
          bar         <= w_bar;
          clip        <= r_clip | w_clip_cond;
          peak_hold   <= w_hold_next;
          level_valid <= 1'b1;
          r_acc       <= '0;
          r_max       <= 8'd0;
          r_clip      <= 1'b0;
          r_cnt       <= '0;
        end else begin
          r_acc  <= w_sum;
          r_max  <= w_peak;
          r_clip <= r_clip | w_clip_cond;
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// tb/tb_audio_level_meter.sv - directed self-checking bench for audio_level_meter

module tb_audio_level_meter;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] level;
  logic [7:0] peak;
  logic [7:0] peak_hold;
  logic [7:0] bar;
  logic       clip;
  logic       level_valid;

  int checks;
  int errors;

  audio_level_meter #(
    .WINDOW_LOG2(2),
    .DECAY_STEP (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample),
    .level       (level),
    .peak        (peak),
    .peak_hold   (peak_hold),
    .bar         (bar),
    .clip        (clip),
    .level_valid (level_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive one strobe, return at the next negedge,
  // i.e. just after the posedge that accepted it.
  task automatic push(input logic [7:0] s);
    sample_valid = 1'b1;
    sample       = s;
    @(negedge clk);
    sample_valid = 1'b0;
    sample       = 8'd128;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_window(input string tag, input logic [7:0] e_level,
                              input logic [7:0] e_peak, input logic [7:0] e_hold,
                              input logic [7:0] e_bar, input logic e_clip);
    check({tag, "_valid"}, {7'd0, level_valid}, 8'd1);
    check({tag, "_level"}, level, e_level);
    check({tag, "_peak"},  peak, e_peak);
    check({tag, "_hold"},  peak_hold, e_hold);
    check({tag, "_bar"},   bar, e_bar);
    check({tag, "_clip"},  {7'd0, clip}, {7'd0, e_clip});
  endtask

  int pulses;
  logic [7:0] lv_trace [0:9];

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = 8'd128;
    idle(3);
    check("reset_valid", {7'd0, level_valid}, 8'd0);
    check("reset_level", level, 8'd0);
    check("reset_peak",  peak, 8'd0);
    check("reset_hold",  peak_hold, 8'd0);
    check("reset_bar",   bar, 8'd0);
    check("reset_clip",  {7'd0, clip}, 8'd0);
    rst = 1'b0;
    idle(2);

    // Silent window: all samples at midscale.
    for (int i = 0; i < 3; i++) begin
      push(8'd128);
      check("silent_no_early_valid", {7'd0, level_valid}, 8'd0);
    end
    push(8'd128);
    check_window("silent", 8'd0, 8'd0, 8'd0, 8'h00, 1'b0);
    idle(1);
    check("silent_pulse_one_cycle", {7'd0, level_valid}, 8'd0);

    // Mixed window: mags 128,127,0,64 -> sum 319, mean 79.
    push(8'd0);
    push(8'd255);
    push(8'd128);
    push(8'd192);
    check_window("mixed", 8'd79, 8'd128, 8'd128, 8'h0F, 1'b1);
    idle(3);
    check("mixed_hold_level", level, 8'd79);
    check("mixed_hold_clip",  {7'd0, clip}, 8'd1);

    // Two quiet windows: peak hold decays 128 -> 112 -> 96.
    for (int i = 0; i < 4; i++) push(8'd128);
    check_window("decay1", 8'd0, 8'd0, 8'd112, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) push(8'd128);
    check_window("decay2", 8'd0, 8'd0, 8'd96, 8'h00, 1'b0);
    idle(1);

    // Partial window discarded by reset.
    push(8'd0);
    push(8'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hold", peak_hold, 8'd0);
    check("midrst_level", level, 8'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      push(8'd192);
      if (level_valid) pulses++;
    end
    push(8'd192);
    check_window("midrst", 8'd64, 8'd64, 8'd64, 8'h0F, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (level_valid) pulses++;
    end
    check("midrst_extra_pulses", 8'(pulses), 8'd0);

    // Back-to-back strobes: mags 32, pulses after strobes 4 and 8.
    sample_valid = 1'b1;
    sample       = 8'd160;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 7) begin
        sample_valid = 1'b0;
        sample       = 8'd128;
      end
      lv_trace[i] = {7'd0, level_valid};
      if (i == 3) check_window("b2b_w1", 8'd32, 8'd32, 8'd48, 8'h03, 1'b0);
      if (i == 7) check_window("b2b_w2", 8'd32, 8'd32, 8'd32, 8'h03, 1'b0);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) if (lv_trace[i] == 8'd1) pulses++;
    check("b2b_pulse_count", 8'(pulses), 8'd2);
    check("b2b_gap_mid", lv_trace[5], 8'd0);

    // Strobe coincident with reset must be ignored.
    rst          = 1'b1;
    sample_valid = 1'b1;
    sample       = 8'd0;
    @(negedge clk);
    rst          = 1'b0;
    sample_valid = 1'b0;
    sample       = 8'd128;
    for (int i = 0; i < 3; i++) begin
      push(8'd128);
      check("rststrobe_no_early_valid", {7'd0, level_valid}, 8'd0);
    end
    idle(2);
    check("rststrobe_still_waiting", {7'd0, level_valid}, 8'd0);
    push(8'd128);
    check_window("rststrobe", 8'd0, 8'd0, 8'd0, 8'h00, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
